// File: rtl/prog_interval_timer.sv
// Programmable interval timer: prescaled tick plus a loadable one-shot/periodic down-counter.
// Optional sticky `expired` output is enabled by defining PROG_TIMER_STICKY_EXPIRED_EN.
module prog_interval_timer #(
   parameter int CLK_PER_TICK = 50000,
   parameter int PRE_W        = 16,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             periodic,
   output logic             tick_pulse,
   output logic             done_pulse,
   output logic [CNT_W-1:0] count,
   output logic             running
`ifdef PROG_TIMER_STICKY_EXPIRED_EN
   ,
   output logic             expired
`endif
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RUN     = 2'd1;
   localparam logic [1:0] EXPIRED = 2'd2;

   logic [1:0]       state;
   logic [PRE_W-1:0] pre_cnt;
   logic [CNT_W-1:0] reload_reg;
   logic             mode_reg;
   logic             tick_t;
   logic             last_tick;

   assign tick_t    = enable && (pre_cnt == PRE_W'(CLK_PER_TICK - 1));
   // Final tick of an interval; a coincident load wins and suppresses it.
   assign last_tick = tick_t && !load && (state == RUN) && (count == CNT_W'(1));
   assign running   = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt    <= '0;
         tick_pulse <= 1'b0;
         done_pulse <= 1'b0;
         count      <= '0;
         reload_reg <= '0;
         mode_reg   <= 1'b0;
         state      <= IDLE;
      end else begin
         tick_pulse <= 1'b0;
         done_pulse <= 1'b0;
         if (load) begin
            count      <= load_val;
            reload_reg <= load_val;
            mode_reg   <= periodic;
            pre_cnt    <= '0;
            state      <= (load_val != '0) ? RUN : IDLE;
         end else begin
            if (!enable) begin
               pre_cnt <= '0;
            end else if (tick_t) begin
               pre_cnt    <= '0;
               tick_pulse <= 1'b1;
            end else begin
               pre_cnt <= pre_cnt + PRE_W'(1);
            end

            if (tick_t && state == RUN) begin
               if (count > CNT_W'(1)) begin
                  count <= count - CNT_W'(1);
               end else if (mode_reg) begin
                  count      <= reload_reg;
                  done_pulse <= 1'b1;
               end else begin
                  count      <= '0;
                  done_pulse <= 1'b1;
                  state      <= EXPIRED;
               end
            end
         end
      end
   end

`ifdef PROG_TIMER_STICKY_EXPIRED_EN
   always_ff @(posedge clk) begin
      if (rst || load)
         expired <= 1'b0;
      else if (last_tick)
         expired <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_prog_interval_timer.sv
// Directed self-checking bench for prog_interval_timer with CLK_PER_TICK=4.
module tb_prog_interval_timer;

   localparam int CPT = 4;
   localparam int PW  = 4;
   localparam int CW  = 8;

   logic          clk = 1'b0;
   logic          rst, enable, load, periodic;
   logic [CW-1:0] load_val;
   logic          tick_pulse, done_pulse, running;
   logic [CW-1:0] count;
`ifdef PROG_TIMER_STICKY_EXPIRED_EN
   logic          expired;
`endif

   int total = 0;
   int bad   = 0;

   prog_interval_timer #(.CLK_PER_TICK(CPT), .PRE_W(PW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .load_val   (load_val),
      .periodic   (periodic),
      .tick_pulse (tick_pulse),
      .done_pulse (done_pulse),
      .count      (count),
      .running    (running)
`ifdef PROG_TIMER_STICKY_EXPIRED_EN
      ,
      .expired    (expired)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle so outputs reflect that edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int v, input logic p);
      load = 1'b1; load_val = CW'(v); periodic = p;
      step();
      load = 1'b0;
   endtask

   initial begin
      int k;
      rst = 1'b1; enable = 1'b0; load = 1'b0; load_val = '0; periodic = 1'b0;
      step(); step();
      chk("rst_tick", tick_pulse, 0);
      chk("rst_done", done_pulse, 0);
      chk("rst_count", count, 0);
      chk("rst_running", running, 0);
`ifdef PROG_TIMER_STICKY_EXPIRED_EN
      chk("rst_expired", expired, 0);
`endif

      // Free-running prescaler, no interval loaded
      rst = 1'b0; enable = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         step();
         chk($sformatf("idle_tick_e%0d", e), tick_pulse, (e % 4 == 0) ? 1 : 0);
         chk($sformatf("idle_done_e%0d", e), done_pulse, 0);
      end
      chk("idle_count", count, 0);
      chk("idle_running", running, 0);

      // One-shot of 3 ticks
      do_load(3, 1'b0);
      chk("os_count0", count, 3);
      chk("os_running0", running, 1);
      for (int e = 1; e <= 12; e++) begin
         step();
         chk($sformatf("os_count_e%0d", e), count, (e < 4) ? 3 : (e < 8) ? 2 : (e < 12) ? 1 : 0);
         chk($sformatf("os_done_e%0d", e), done_pulse, (e == 12) ? 1 : 0);
         chk($sformatf("os_tick_e%0d", e), tick_pulse, (e % 4 == 0) ? 1 : 0);
      end
      chk("os_running_end", running, 0);
`ifdef PROG_TIMER_STICKY_EXPIRED_EN
      chk("os_expired", expired, 1);
`endif
      for (int e = 1; e <= 32; e++) begin
         step();
         chk($sformatf("exp_done_e%0d", e), done_pulse, 0);
      end
      chk("exp_count_hold", count, 0);
      chk("exp_running", running, 0);

      // Periodic reload of 2 ticks
      do_load(2, 1'b1);
      chk("per_count0", count, 2);
`ifdef PROG_TIMER_STICKY_EXPIRED_EN
      chk("per_expired_cleared", expired, 0);
`endif
      for (int e = 1; e <= 24; e++) begin
         step();
         k = e / 4;
         chk($sformatf("per_count_e%0d", e), count, (k % 2 == 0) ? 2 : 1);
         chk($sformatf("per_done_e%0d", e), done_pulse,
             (e % 4 == 0 && k % 2 == 0) ? 1 : 0);
         chk($sformatf("per_running_e%0d", e), running, 1);
      end
`ifdef PROG_TIMER_STICKY_EXPIRED_EN
      chk("per_expired", expired, 1);
`endif

      // Pause mid-interval: prescaler restarts on re-enable
      do_load(5, 1'b0);
      step(); step();
      enable = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         step();
         chk($sformatf("pause_count_e%0d", e), count, 5);
         chk($sformatf("pause_tick_e%0d", e), tick_pulse, 0);
      end
      chk("pause_running", running, 1);
      enable = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         step();
         chk($sformatf("resume_tick_e%0d", e), tick_pulse, (e == 4) ? 1 : 0);
         chk($sformatf("resume_count_e%0d", e), count, (e == 4) ? 4 : 5);
      end

      // Load coincident with terminal tick while count=1
      do_load(1, 1'b0);
      for (int e = 1; e <= 3; e++) begin
         step();
         chk($sformatf("coin_pre_count_e%0d", e), count, 1);
      end
      do_load(7, 1'b0);
      chk("coin_tick", tick_pulse, 0);
      chk("coin_done", done_pulse, 0);
      chk("coin_count", count, 7);
      chk("coin_running", running, 1);
`ifdef PROG_TIMER_STICKY_EXPIRED_EN
      chk("coin_expired", expired, 0);
`endif

      // Zero-length load goes idle and never completes
      do_load(0, 1'b1);
      chk("zero_count", count, 0);
      chk("zero_running", running, 0);
      for (int e = 1; e <= 8; e++) begin
         step();
         chk($sformatf("zero_done_e%0d", e), done_pulse, 0);
         chk($sformatf("zero_running_e%0d", e), running, 0);
      end

      // Reset mid-run
      do_load(3, 1'b0);
      chk("mid_count", count, 3);
      step(); step();
      rst = 1'b1;
      step();
      chk("mrst_count", count, 0);
      chk("mrst_running", running, 0);
      chk("mrst_tick", tick_pulse, 0);
      chk("mrst_done", done_pulse, 0);
      rst = 1'b0;

      // One-shot of 1 tick after reset
      do_load(1, 1'b0);
      for (int e = 1; e <= 4; e++) begin
         step();
         chk($sformatf("short_done_e%0d", e), done_pulse, (e == 4) ? 1 : 0);
      end
      chk("short_running", running, 0);
`ifdef PROG_TIMER_STICKY_EXPIRED_EN
      chk("short_expired", expired, 1);
      rst = 1'b1;
      step();
      chk("rst_expired_clear", expired, 0);
      rst = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prog_interval_timer.md
Name: prog_interval_timer

Overview:
- Parametrised successor to the fixed millisecond pulse generator.
- A prescaler turns `clk` into a periodic `tick_pulse`.
- A loadable down-counter counts those ticks and flags expiry, in one-shot or auto-reload (periodic) mode.
- Sits between the system clock and game-level logic (move timer, display blink, elapsed-time counters), so one block serves every interval need.

Parameters:
- CLK_PER_TICK, 50000, clk cycles per tick (must be >= 2; benches use 4).
- PRE_W, 16, prescaler counter width (must satisfy 2**PRE_W >= CLK_PER_TICK).
- CNT_W, 16, width of the interval counter and `load_val`.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = prescaler runs and countdown advances; 0 = pause.
- load  in  1  single-cycle strobe; latch `load_val` and start a new interval.
- load_val  in  CNT_W  interval length in ticks.
- periodic  in  1  sampled on `load`; 1 = auto-reload, 0 = one-shot.
- tick_pulse  out  1  one-cycle pulse every CLK_PER_TICK enabled cycles.
- done_pulse  out  1  one-cycle pulse when the interval expires.
- count  out  CNT_W  remaining ticks in the current interval.
- running  out  1  high while in the RUN state.

Behaviour:
- Reset (rst=1 at an edge):
  - pre_cnt=0, tick_pulse=0, done_pulse=0, count=0, running=0.
  - reload_reg=0, mode_reg=0, state=IDLE.
  - Reset overrides every other input.
- Prescaler:
  - enable=0: pre_cnt cleared to 0, tick_pulse=0. A pause therefore restarts the current tick.
  - enable=1 and pre_cnt < CLK_PER_TICK-1: pre_cnt += 1, tick_pulse=0.
  - enable=1 and pre_cnt = CLK_PER_TICK-1: pre_cnt=0, tick_pulse=1 for exactly one cycle.
  - Timing: with enable held high, the first tick_pulse is high after the CLK_PER_TICK-th enabled edge; after that, one pulse every CLK_PER_TICK cycles.
  - tick_t is the internal, combinational terminal condition that drives these updates. It is (enable=1 and pre_cnt = CLK_PER_TICK-1).
- States: IDLE, RUN, EXPIRED. running = (state==RUN).
- Priority: rst > load > tick_t.
- `load` (accepted in any state, whether or not enable is high):
  - count=load_val, reload_reg=load_val, mode_reg=periodic, pre_cnt=0, done_pulse=0.
  - Next state is RUN if load_val != 0, else IDLE.
  - load_val=0 never produces done_pulse.
  - tick_pulse is forced to 0 in the load cycle.
- RUN on tick_t:
  - count > 1: count -= 1.
  - count = 1 and mode_reg=1: count=reload_reg, done_pulse=1, stay in RUN.
  - count = 1 and mode_reg=0: count=0, done_pulse=1, go to EXPIRED.
- IDLE and EXPIRED:
  - tick_t still produces tick_pulse.
  - count holds its value; done_pulse=0.
  - Only `load` leaves these states.
- done_pulse is registered and asserts on the same edge as the matching tick_pulse.
- enable=0 in RUN freezes count and state.
- Arithmetic is unsigned; count never wraps below 0.
- rst asserted mid-interval returns to the reset values on that edge.

Optional Feature:
- Macro: PROG_TIMER_STICKY_EXPIRED_EN.
- Defined: adds output `expired` (1 bit).
  - Reset value 0.
  - Set on the edge where done_pulse asserts, in both modes.
  - Cleared only by `load` or rst. `load` takes priority over setting.
- Undefined: the `expired` port and its register do not exist; all other behaviour is identical.

Test Plan (CLK_PER_TICK=4):
- Reset, then enable=1 for 12 cycles, no load -> tick_pulse high on enabled edges 4, 8, 12 only; count=0; running=0; done_pulse never asserts.
- load_val=3, periodic=0, enable=1 -> count steps 3, 2, 1, 0 on edges 4, 8, 12 after load. done_pulse is high on edge 12 only. State becomes EXPIRED, running=0, and count stays 0 through 8 more ticks.
- load_val=2, periodic=1 -> done_pulse on ticks 2, 4, 6. count sequence is 2, 1, 2, 1, 2. running stays 1.
- Mid-interval pause: load 5, run 2 cycles, drop enable for 10 cycles, then raise it -> count holds 5 and the next tick arrives 4 enabled cycles after re-enable.
- `load` coincident with tick_t while count=1 -> no done_pulse, no tick_pulse; count = new load_val. Also, load_val=0 -> state IDLE, no done_pulse.
- rst asserted mid-RUN with count=3 -> next edge: all outputs at reset values. With the macro defined, `expired` is also 0 after reset and set after a one-shot expiry.
